dbg_uart_loader: RTL and testbench
==================================

Name: dbg_uart_loader

Overview:
- Debug command engine between the UART receiver/transmitter and the SoC debug memory port (dbg_mem_op / dbg_wren / dbg_adr / dbg_do).
- Parses a byte-oriented command stream from the host and holds or releases the CPU reset.
- Issues word writes and reads to memory while the CPU is held in reset, then returns acks or read data.
- It is the hardware producer of the debug-port signals that system benches currently force by hand.

Parameters:
- TIMEOUT_CYCLES, 1000000: inter-byte timeout inside a command, in clk cycles.
- HOLD_ON_RESET, 1: value of cpu_hold after n_reset; 1 = CPU held in reset after power-up.

Ports:
- clk  in  1  system clock
- n_reset  in  1  asynchronous active-low reset
- rx_data  in  8  received UART byte
- rx_valid  in  1  one-cycle strobe; rx_data valid
- tx_data  out  8  byte to transmit
- tx_valid  out  1  tx_data valid; held until tx_ready
- tx_ready  in  1  transmitter accepts tx_data when tx_valid & tx_ready
- cpu_n_reset  out  1  CPU reset, active-low (equals ~cpu_hold)
- dbg_mem_op  out  1  debug port owns memory bus
- dbg_wren  out  4  byte write enables
- dbg_adr  out  32  word address, bits [1:0] always 0
- dbg_do  out  32  write data
- dbg_di  in  32  read data, valid when dbg_ready
- dbg_ready  in  1  memory completed access this cycle

Behaviour:

Reset values:
- All outputs 0, except cpu_n_reset = ~HOLD_ON_RESET.
- State = IDLE.

Commands (first byte; multi-byte fields little-endian):
- 0x48 'H': set cpu_hold = 1, reply 0x06.
- 0x47 'G': set cpu_hold = 0, reply 0x06.
- 0x57 'W': A0..A3, D0..D3. Write word D to address A, mask 0xF. Reply 0x06.
- 0x52 'R': A0..A3. Read word at A. Reply 4 bytes, LSB first.
- Any other byte in IDLE: reply 0x15 (NAK), stay in IDLE.

States: IDLE -> ADDR -> (DATA if W) -> MEM -> RESP -> IDLE.
- ADDR and DATA each consume 4 rx_valid strobes, tracked by a 2-bit byte counter.
- W/R while cpu_hold = 0: the command's bytes are still consumed. MEM is skipped and the reply is a single 0x15.

MEM:
- dbg_adr = {A[31:2], 2'b00}.
- dbg_do = D; dbg_wren = 4'hF for W, 4'h0 for R.
- dbg_mem_op = 1 from the first cycle of MEM until the cycle dbg_ready = 1 (inclusive). It drops the next cycle.
- For R, dbg_di is captured on the dbg_ready cycle.
- There is no timeout in MEM.

RESP:
- tx_valid asserts the cycle after entry.
- Each byte is held stable until tx_ready; the next byte is presented the cycle after the handshake.
- IDLE is re-entered the cycle after the last handshake.

rx_valid handling:
- rx_valid while in MEM or RESP: byte dropped, no state effect.

Timeout:
- Counter clears on every accepted byte and counts only in ADDR/DATA.
- Reaching TIMEOUT_CYCLES returns to IDLE with no reply and no memory access.

cpu_n_reset:
- Changes the cycle after the H/G byte.
- Its reply 0x06 enters RESP on that same cycle.

Reset mid-operation:
- Async clear of everything, including dbg_mem_op and tx_valid, immediately.

Test Plan:
1. After reset with HOLD_ON_RESET=1: cpu_n_reset = 0, dbg_mem_op = 0. Send 57 00 00 02 00 37 01 00 00 -> one MEM cycle with dbg_adr = 0x00020000, dbg_do = 0x00000137, dbg_wren = F; tx 06.
2. Send 52 0C 00 00 00, model returns dbg_di = 0x00003132 after a 3-cycle dbg_ready delay -> dbg_mem_op high exactly 4 cycles, wren = 0; tx 32 31 00 00 in order, with tx_ready throttled to every 5th cycle.
3. Send 47 -> cpu_n_reset rises, tx 06. Then 57 + 8 bytes -> no dbg_mem_op, tx 15. Then 48 -> cpu_n_reset = 0, tx 06.
4. Send 57 with address byte A0 = 0x0F -> dbg_adr low 2 bits = 00. Send unknown 0xAA -> tx 15, next valid command accepted.
5. TIMEOUT_CYCLES=50: send 57 00 00, then idle 60 cycles -> back in IDLE, no tx, no mem op. Following 48 -> tx 06.
6. Pulse n_reset low while dbg_mem_op = 1 with dbg_ready held 0 -> dbg_mem_op and tx_valid drop asynchronously, state IDLE, cpu_n_reset = 0.

Source files
------------

// File: rtl/dbg_uart_loader.sv
// Debug command engine: turns a host byte stream into CPU hold/release control
// and word accesses on the debug memory port, replying with acks or read data.
module dbg_uart_loader #(
   parameter int unsigned TIMEOUT_CYCLES = 1000000,
   parameter bit          HOLD_ON_RESET  = 1'b1
) (
   input  logic        clk,
   input  logic        n_reset,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        cpu_n_reset,
   output logic        dbg_mem_op,
   output logic [3:0]  dbg_wren,
   output logic [31:0] dbg_adr,
   output logic [31:0] dbg_do,
   input  logic [31:0] dbg_di,
   input  logic        dbg_ready
);

   typedef enum logic [2:0] {IDLE, ADDR, DATA, MEM, RESP} state_t;

   localparam logic [7:0]  CMD_HOLD = 8'h48;
   localparam logic [7:0]  CMD_GO   = 8'h47;
   localparam logic [7:0]  CMD_WR   = 8'h57;
   localparam logic [7:0]  CMD_RD   = 8'h52;
   localparam logic [7:0]  ACK      = 8'h06;
   localparam logic [7:0]  NAK      = 8'h15;
   localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

   state_t      state;
   logic [1:0]  byte_cnt;
   logic        is_write;
   logic        cpu_hold;
   logic [23:0] addr_sh;
   logic [23:0] data_sh;
   logic [31:0] resp;
   logic [1:0]  resp_left;
   logic [31:0] tmo_cnt;

   assign cpu_n_reset = ~cpu_hold;

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state      <= IDLE;
         byte_cnt   <= 2'd0;
         is_write   <= 1'b0;
         cpu_hold   <= HOLD_ON_RESET;
         addr_sh    <= 24'd0;
         data_sh    <= 24'd0;
         resp       <= 32'd0;
         resp_left  <= 2'd0;
         tmo_cnt    <= 32'd0;
         tx_data    <= 8'd0;
         tx_valid   <= 1'b0;
         dbg_mem_op <= 1'b0;
         dbg_wren   <= 4'h0;
         dbg_adr    <= 32'd0;
         dbg_do     <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               tmo_cnt  <= 32'd0;
               byte_cnt <= 2'd0;
               if (rx_valid) begin
                  case (rx_data)
                     CMD_HOLD: begin
                        cpu_hold  <= 1'b1;
                        resp      <= {24'd0, ACK};
                        resp_left <= 2'd0;
                        state     <= RESP;
                     end
                     CMD_GO: begin
                        cpu_hold  <= 1'b0;
                        resp      <= {24'd0, ACK};
                        resp_left <= 2'd0;
                        state     <= RESP;
                     end
                     CMD_WR: begin
                        is_write <= 1'b1;
                        state    <= ADDR;
                     end
                     CMD_RD: begin
                        is_write <= 1'b0;
                        state    <= ADDR;
                     end
                     default: begin
                        resp      <= {24'd0, NAK};
                        resp_left <= 2'd0;
                        state     <= RESP;
                     end
                  endcase
               end
            end

            // Address bytes arrive LSB first; the full word lands in dbg_adr on the 4th byte
            ADDR: begin
               if (rx_valid) begin
                  tmo_cnt  <= 32'd0;
                  byte_cnt <= byte_cnt + 2'd1;
                  addr_sh  <= {rx_data, addr_sh[23:8]};
                  if (byte_cnt == 2'd3) begin
                     dbg_adr <= {rx_data, addr_sh} & 32'hFFFF_FFFC;
                     if (is_write) begin
                        state <= DATA;
                     end else if (cpu_hold) begin
                        dbg_mem_op <= 1'b1;
                        dbg_wren   <= 4'h0;
                        state      <= MEM;
                     end else begin
                        resp      <= {24'd0, NAK};
                        resp_left <= 2'd0;
                        state     <= RESP;
                     end
                  end
               end else if (tmo_cnt == TMO_LAST) begin
                  state <= IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + 32'd1;
               end
            end

            DATA: begin
               if (rx_valid) begin
                  tmo_cnt  <= 32'd0;
                  byte_cnt <= byte_cnt + 2'd1;
                  data_sh  <= {rx_data, data_sh[23:8]};
                  if (byte_cnt == 2'd3) begin
                     if (cpu_hold) begin
                        dbg_do     <= {rx_data, data_sh};
                        dbg_mem_op <= 1'b1;
                        dbg_wren   <= 4'hF;
                        state      <= MEM;
                     end else begin
                        resp      <= {24'd0, NAK};
                        resp_left <= 2'd0;
                        state     <= RESP;
                     end
                  end
               end else if (tmo_cnt == TMO_LAST) begin
                  state <= IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + 32'd1;
               end
            end

            // Waits indefinitely for the memory; read data is taken on the ready cycle
            MEM: begin
               if (dbg_ready) begin
                  dbg_mem_op <= 1'b0;
                  dbg_wren   <= 4'h0;
                  resp       <= is_write ? {24'd0, ACK} : dbg_di;
                  resp_left  <= is_write ? 2'd0 : 2'd3;
                  state      <= RESP;
               end
            end

            RESP: begin
               if (!tx_valid) begin
                  tx_valid <= 1'b1;
                  tx_data  <= resp[7:0];
               end else if (tx_ready) begin
                  if (resp_left == 2'd0) begin
                     tx_valid <= 1'b0;
                     state    <= IDLE;
                  end else begin
                     tx_data   <= resp[15:8];
                     resp      <= {8'd0, resp[31:8]};
                     resp_left <= resp_left - 2'd1;
                  end
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dbg_uart_loader.sv
// Directed bench for dbg_uart_loader: byte commands in, memory port and tx bytes checked.
module tb_dbg_uart_loader;

   logic        clk = 1'b0;
   logic        n_reset;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        cpu_n_reset;
   logic        dbg_mem_op;
   logic [3:0]  dbg_wren;
   logic [31:0] dbg_adr;
   logic [31:0] dbg_do;
   logic [31:0] dbg_di;
   logic        dbg_ready;

   int n_tests = 0;
   int n_fail  = 0;

   int mem_delay = 0;
   int mcnt      = 0;
   int cyc       = 0;
   bit throttle  = 1'b0;

   logic [7:0]  txq[$];
   int          mem_cycles = 0;
   logic        mem_prev   = 1'b0;
   logic [31:0] cap_adr    = 32'd0;
   logic [31:0] cap_do     = 32'd0;
   logic [3:0]  cap_wren   = 4'd0;

   always #5 clk = ~clk;

   dbg_uart_loader #(.TIMEOUT_CYCLES(50), .HOLD_ON_RESET(1'b1)) dut (
      .clk         (clk),
      .n_reset     (n_reset),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .cpu_n_reset (cpu_n_reset),
      .dbg_mem_op  (dbg_mem_op),
      .dbg_wren    (dbg_wren),
      .dbg_adr     (dbg_adr),
      .dbg_do      (dbg_do),
      .dbg_di      (dbg_di),
      .dbg_ready   (dbg_ready)
   );

   // Memory model: ready after mem_delay wait cycles; read data only valid on ready
   assign dbg_ready = dbg_mem_op && (mcnt == mem_delay);
   assign dbg_di    = dbg_ready ? 32'h0000_3132 : 32'hDEAD_BEEF;

   always @(posedge clk) begin
      if (!dbg_mem_op || dbg_ready) mcnt <= 0;
      else                          mcnt <= mcnt + 1;
      cyc <= cyc + 1;
   end

   always @(posedge clk) begin
      #1;
      tx_ready = throttle ? ((cyc % 5) == 0) : 1'b1;
   end

   always @(negedge clk) begin
      if (dbg_mem_op) begin
         if (!mem_prev) begin
            cap_adr  = dbg_adr;
            cap_do   = dbg_do;
            cap_wren = dbg_wren;
         end
         mem_cycles++;
      end
      mem_prev = dbg_mem_op;
      if (tx_valid && tx_ready) txq.push_back(tx_data);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] txb(input int i);
      if (i < txq.size()) return txq[i];
      return 8'hxx;
   endfunction

   task automatic send(input logic [7:0] b);
      @(posedge clk);
      #1;
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic send_seq(input logic [7:0] bytes[$]);
      foreach (bytes[i]) send(bytes[i]);
   endtask

   task automatic clr();
      txq.delete();
      mem_cycles = 0;
   endtask

   task automatic wait_tx(input int n);
      for (int i = 0; i < 400 && txq.size() < n; i++) @(posedge clk);
      repeat (10) @(posedge clk);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, time %0t, limit 300000", $time);
      $fatal(1);
   end

   initial begin
      n_reset  = 1'b0;
      rx_data  = 8'd0;
      rx_valid = 1'b0;
      tx_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_reset = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_cpu_n_reset", 32'(cpu_n_reset), 32'd0);
      chk("rst_mem_op", 32'(dbg_mem_op), 32'd0);
      chk("rst_tx_valid", 32'(tx_valid), 32'd0);
      chk("rst_wren", 32'(dbg_wren), 32'd0);
      chk("rst_adr", dbg_adr, 32'd0);

      // 1: word write
      clr();
      send_seq('{8'h57, 8'h00, 8'h00, 8'h02, 8'h00, 8'h37, 8'h01, 8'h00, 8'h00});
      wait_tx(1);
      chk("w1_mem_cycles", 32'(mem_cycles), 32'd1);
      chk("w1_adr", cap_adr, 32'h0002_0000);
      chk("w1_do", cap_do, 32'h0000_0137);
      chk("w1_wren", 32'(cap_wren), 32'hF);
      chk("w1_tx_n", 32'(txq.size()), 32'd1);
      chk("w1_tx0", 32'(txb(0)), 32'h06);

      // 2: read with slow memory and throttled transmitter
      clr();
      mem_delay = 3;
      throttle  = 1'b1;
      send_seq('{8'h52, 8'h0C, 8'h00, 8'h00, 8'h00});
      wait_tx(4);
      throttle  = 1'b0;
      mem_delay = 0;
      chk("r2_mem_cycles", 32'(mem_cycles), 32'd4);
      chk("r2_wren", 32'(cap_wren), 32'h0);
      chk("r2_adr", cap_adr, 32'h0000_000C);
      chk("r2_tx_n", 32'(txq.size()), 32'd4);
      chk("r2_tx0", 32'(txb(0)), 32'h32);
      chk("r2_tx1", 32'(txb(1)), 32'h31);
      chk("r2_tx2", 32'(txb(2)), 32'h00);
      chk("r2_tx3", 32'(txb(3)), 32'h00);

      // 3: release CPU, write refused, hold again
      clr();
      send(8'h47);
      chk("g3_cpu_n_reset", 32'(cpu_n_reset), 32'd1);
      wait_tx(1);
      chk("g3_tx_n", 32'(txq.size()), 32'd1);
      chk("g3_tx0", 32'(txb(0)), 32'h06);
      clr();
      send_seq('{8'h57, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88});
      wait_tx(1);
      chk("w3_mem_cycles", 32'(mem_cycles), 32'd0);
      chk("w3_tx_n", 32'(txq.size()), 32'd1);
      chk("w3_tx0", 32'(txb(0)), 32'h15);
      clr();
      send(8'h48);
      chk("h3_cpu_n_reset", 32'(cpu_n_reset), 32'd0);
      wait_tx(1);
      chk("h3_tx0", 32'(txb(0)), 32'h06);

      // 4: unaligned address, unknown command, then a read
      clr();
      send_seq('{8'h57, 8'h0F, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE});
      wait_tx(1);
      chk("w4_adr", cap_adr, 32'h0000_000C);
      chk("w4_do", cap_do, 32'hDEAD_BEEF);
      chk("w4_tx0", 32'(txb(0)), 32'h06);
      clr();
      send(8'hAA);
      wait_tx(1);
      chk("u4_tx_n", 32'(txq.size()), 32'd1);
      chk("u4_tx0", 32'(txb(0)), 32'h15);
      chk("u4_mem_cycles", 32'(mem_cycles), 32'd0);
      clr();
      send_seq('{8'h52, 8'h10, 8'h00, 8'h00, 8'h00});
      wait_tx(4);
      chk("r4_mem_cycles", 32'(mem_cycles), 32'd1);
      chk("r4_adr", cap_adr, 32'h0000_0010);
      chk("r4_tx_n", 32'(txq.size()), 32'd4);
      chk("r4_tx0", 32'(txb(0)), 32'h32);

      // 5: inter-byte timeout abandons a partial command
      clr();
      send_seq('{8'h57, 8'h00, 8'h00});
      repeat (60) @(posedge clk);
      chk("t5_tx_n", 32'(txq.size()), 32'd0);
      chk("t5_mem_cycles", 32'(mem_cycles), 32'd0);
      send(8'h48);
      wait_tx(1);
      chk("t5_after_tx_n", 32'(txq.size()), 32'd1);
      chk("t5_after_tx0", 32'(txb(0)), 32'h06);

      // 6: asynchronous reset while memory access is stalled
      clr();
      mem_delay = 1000;
      send_seq('{8'h52, 8'h00, 8'h01, 8'h00, 8'h00});
      for (int i = 0; i < 50 && !dbg_mem_op; i++) @(posedge clk);
      chk("a6_mem_op_up", 32'(dbg_mem_op), 32'd1);
      #2;
      n_reset = 1'b0;
      #1;
      chk("a6_mem_op", 32'(dbg_mem_op), 32'd0);
      chk("a6_tx_valid", 32'(tx_valid), 32'd0);
      chk("a6_cpu_n_reset", 32'(cpu_n_reset), 32'd0);
      chk("a6_wren", 32'(dbg_wren), 32'd0);
      @(posedge clk);
      #1;
      n_reset   = 1'b1;
      mem_delay = 0;
      clr();
      send(8'h48);
      wait_tx(1);
      chk("a6_after_tx_n", 32'(txq.size()), 32'd1);
      chk("a6_after_tx0", 32'(txb(0)), 32'h06);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
